// File: rtl/invader_sprite.sv
// invader_sprite: paint stage that draws one 8x8 space-invader bitmap,
// scaled by SCALE, on a dark blue background. The sprite marches
// sideways once per frame, drops a row at each screen edge and wraps
// back to the top after reaching the bottom. Colour and the
// hsync/vsync/de strobes leave the block with a common 2-cycle latency.
//
// Optional build macro: INVADER_ANIM_EN
//   When defined, a frame counter alternates between two bitmap poses
//   every ANIM_FRAMES frames. When undefined, pose A is drawn on every
//   frame and no counter hardware exists.

module invader_sprite #(
    parameter int CORDW       = 10,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SCALE       = 4,
    parameter int SPEED       = 2,
    parameter int DROP        = 8,
    parameter int X0          = 16,
    parameter int Y0          = 32,
    parameter int ANIM_FRAMES = 30
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [3:0]       r_o,
    output logic [3:0]       g_o,
    output logic [3:0]       b_o,
    output logic [CORDW-1:0] spr_x,
    output logic [CORDW-1:0] spr_y
);

    // Sprite footprint on screen and the shift that replaces division.
    localparam int W     = 8 * SCALE;
    localparam int H     = 8 * SCALE;
    localparam int SHIFT = $clog2(SCALE);

    // Boundary constants, one bit wider than a coordinate so the
    // edge tests cannot overflow.
    localparam logic [CORDW:0] STEP_R_E   = (CORDW+1)'(SPEED + W);
    localparam logic [CORDW:0] STEP_D_E   = (CORDW+1)'(DROP + H);
    localparam logic [CORDW:0] H_RES_E    = (CORDW+1)'(H_RES);
    localparam logic [CORDW:0] V_RES_E    = (CORDW+1)'(V_RES);
    localparam logic [CORDW:0] LEFT_LIM_E = (CORDW+1)'(X0 + SPEED);
    localparam logic [CORDW:0] W_E        = (CORDW+1)'(W);
    localparam logic [CORDW:0] H_E        = (CORDW+1)'(H);

    // Movement states.
    localparam logic [1:0] MOVE_R = 2'd0;
    localparam logic [1:0] DROP_L = 2'd1;
    localparam logic [1:0] MOVE_L = 2'd2;
    localparam logic [1:0] DROP_R = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CORDW-1:0] spr_x_q, spr_x_d;
    logic [CORDW-1:0] spr_y_q, spr_y_d;

    logic             frame;

    logic             hit_d, hit_q;
    logic [2:0]       row_d, row_q;
    logic [2:0]       col_d, col_q;
    logic             hs1_q, vs1_q, de1_q;

    logic             pose;
    logic [7:0]       rowBits;
    logic             pix;
    logic [3:0]       r_d, g_d, b_d;
    logic [3:0]       r_q, g_q, b_q;
    logic             hs2_q, vs2_q, de2_q;

    logic [CORDW:0]   sxE, syE, xE, yE;
    logic [CORDW:0]   dx, dy;

    // One pulse per frame, on the first pixel of the first blanking line,
    // so position updates never land inside active video.
    assign frame = (sy == CORDW'(V_RES)) && (sx == '0);

    assign sxE = {1'b0, sx};
    assign syE = {1'b0, sy};
    assign xE  = {1'b0, spr_x_q};
    assign yE  = {1'b0, spr_y_q};
    assign dx  = sxE - xE;
    assign dy  = syE - yE;

    // Bitmap rows for both poses; bit 7 is the leftmost column.
    function automatic logic [7:0] bitmapRow(input logic [2:0] row, input logic poseB);
        logic [7:0] bits;
        case (row)
            3'd0:    bits = 8'h18;
            3'd1:    bits = 8'h3C;
            3'd2:    bits = 8'h7E;
            3'd3:    bits = 8'hDB;
            3'd4:    bits = 8'hFF;
            3'd5:    bits = poseB ? 8'h5A : 8'h24;
            3'd6:    bits = poseB ? 8'h81 : 8'h5A;
            default: bits = poseB ? 8'h42 : 8'hA5;
        endcase
        return bits;
    endfunction

    // Movement decision: march, detect an edge, then drop and reverse.
    always_comb begin
        state_d = state_q;
        spr_x_d = spr_x_q;
        spr_y_d = spr_y_q;
        if (frame) begin
            case (state_q)
                MOVE_R: begin
                    if (xE + STEP_R_E > H_RES_E) begin
                        state_d = DROP_L;
                    end else begin
                        spr_x_d = spr_x_q + CORDW'(SPEED);
                    end
                end
                MOVE_L: begin
                    if (xE < LEFT_LIM_E) begin
                        state_d = DROP_R;
                    end else begin
                        spr_x_d = spr_x_q - CORDW'(SPEED);
                    end
                end
                DROP_L, DROP_R: begin
                    if (yE + STEP_D_E > V_RES_E) begin
                        spr_y_d = CORDW'(Y0);
                    end else begin
                        spr_y_d = spr_y_q + CORDW'(DROP);
                    end
                    state_d = (state_q == DROP_L) ? MOVE_L : MOVE_R;
                end
                default: state_d = MOVE_R;
            endcase
        end
    end

    // Position and movement state registers; reset wins over a frame pulse.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q <= MOVE_R;
            spr_x_q <= CORDW'(X0);
            spr_y_q <= CORDW'(Y0);
        end else begin
            state_q <= state_d;
            spr_x_q <= spr_x_d;
            spr_y_q <= spr_y_d;
        end
    end

    assign spr_x = spr_x_q;
    assign spr_y = spr_y_q;

`ifdef INVADER_ANIM_EN
    localparam int ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic [ANIM_W-1:0] animCnt_q, animCnt_d;
    logic              pose_q, pose_d;

    // Count frames and flip the pose each time the count wraps.
    always_comb begin
        animCnt_d = animCnt_q;
        pose_d    = pose_q;
        if (frame) begin
            if (animCnt_q == ANIM_W'(ANIM_FRAMES - 1)) begin
                animCnt_d = '0;
                pose_d    = ~pose_q;
            end else begin
                animCnt_d = animCnt_q + 1'b1;
            end
        end
    end

    // Animation counter and pose registers.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            animCnt_q <= '0;
            pose_q    <= 1'b0;
        end else begin
            animCnt_q <= animCnt_d;
            pose_q    <= pose_d;
        end
    end

    assign pose = pose_q;
`else
    // Pose A only; the expression is constant false for any frame count.
    assign pose = (ANIM_FRAMES < 0);
`endif

    // Stage 1 decode: is the beam inside the sprite box, and which cell.
    always_comb begin
        hit_d = (sxE >= xE) && (sxE < xE + W_E) &&
                (syE >= yE) && (syE < yE + H_E);
        col_d = 3'(dx >> SHIFT);
        row_d = 3'(dy >> SHIFT);
    end

    // Stage 2 colour: green where the bitmap bit is set, dark blue elsewhere.
    always_comb begin
        rowBits = bitmapRow(row_q, pose);
        pix     = hit_q && rowBits[3'd7 - col_q];
        r_d     = 4'h0;
        g_d     = 4'h0;
        b_d     = 4'h0;
        if (de1_q) begin
            if (pix) begin
                g_d = 4'hF;
            end else begin
                b_d = 4'h2;
            end
        end
    end

    // Two pipeline stages carrying decode, colour and the sync strobes.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            hit_q <= 1'b0;
            row_q <= 3'd0;
            col_q <= 3'd0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
            de1_q <= 1'b0;
            r_q   <= 4'h0;
            g_q   <= 4'h0;
            b_q   <= 4'h0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
            de2_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
            row_q <= row_d;
            col_q <= col_d;
            hs1_q <= hsync_i;
            vs1_q <= vsync_i;
            de1_q <= de_i;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= de1_q;
        end
    end

    assign r_o     = r_q;
    assign g_o     = g_q;
    assign b_o     = b_q;
    assign hsync_o = hs2_q;
    assign vsync_o = vs2_q;
    assign de_o    = de2_q;

endmodule

// File: tb/tb_invader_sprite.sv
// tb_invader_sprite: directed bench for invader_sprite. A trajectory and
// picture model in plain integers predicts every output on every cycle;
// hand-computed literals pin the model at the interesting points.

module tb_invader_sprite;

    localparam int CORDW = 10;
    localparam int ANIM  = 2;
    localparam int SC    = 4;
    localparam int SZ    = 8 * SC;

    logic             clk_pix = 1'b0;
    logic             rst_pix = 1'b1;
    logic [CORDW-1:0] sx = '0;
    logic [CORDW-1:0] sy = '0;
    logic             hsync_i = 1'b0;
    logic             vsync_i = 1'b0;
    logic             de_i = 1'b0;
    logic             hsync_o, vsync_o, de_o;
    logic [3:0]       r_o, g_o, b_o;
    logic [CORDW-1:0] spr_x, spr_y;

    int checks = 0;
    int errors = 0;

    invader_sprite #(
        .CORDW(CORDW), .H_RES(640), .V_RES(480), .SCALE(SC), .SPEED(2),
        .DROP(8), .X0(16), .Y0(32), .ANIM_FRAMES(ANIM)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .r_o(r_o), .g_o(g_o), .b_o(b_o), .spr_x(spr_x), .spr_y(spr_y)
    );

    // Pixel clock.
    always #5 clk_pix = ~clk_pix;

    // Watchdog so the run always ends.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] poseA [8] = '{8'h18, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'hA5};
    logic [7:0] poseB [8] = '{8'h18, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h5A, 8'h81, 8'h42};

    // Model state: trajectory, frame count, and one stage of decoded pixel.
    int  mX = 16, mY = 32, mFrame = 0;
    bit  goingRight = 1'b1, dropPending = 1'b0;
    bit  prevRst = 1'b1, modelValid = 1'b0;
    bit  s1Hit = 1'b0, s1De = 1'b0;
    int  s1Row = 0, s1Col = 0, s1Sync = 0;
    int  expColour = 0, expSync = 0;

    function automatic int currentPose(int frameNo);
`ifdef INVADER_ANIM_EN
        return (frameNo / ANIM) % 2;
`else
        return 0 * frameNo;
`endif
    endfunction

    function automatic bit bitmapBit(int p, int row, int col);
        logic [7:0] rv;
        rv = (p != 0) ? poseB[row] : poseA[row];
        return rv[7 - col];
    endfunction

    // Reference model, advanced once per clock edge.
    always @(posedge clk_pix) begin
        int dx, dy;
        bit pix;
        if (rst_pix || prevRst) begin
            expColour = 0;
            expSync   = 0;
        end else begin
            pix       = s1Hit && bitmapBit(currentPose(mFrame), s1Row, s1Col);
            expColour = s1De ? (pix ? 12'h0F0 : 12'h002) : 0;
            expSync   = s1Sync;
        end
        dx     = int'(sx) - mX;
        dy     = int'(sy) - mY;
        s1Hit  = (dx >= 0) && (dx < SZ) && (dy >= 0) && (dy < SZ);
        s1Col  = s1Hit ? dx / SC : 0;
        s1Row  = s1Hit ? dy / SC : 0;
        s1De   = de_i;
        s1Sync = {hsync_i, vsync_i, de_i};
        if (rst_pix) begin
            mX = 16; mY = 32; mFrame = 0;
            goingRight = 1'b1; dropPending = 1'b0;
        end else if (int'(sy) == 480 && int'(sx) == 0) begin
            mFrame++;
            if (dropPending) begin
                mY = (mY + 8 + SZ > 480) ? 32 : mY + 8;
                dropPending = 1'b0;
                goingRight = !goingRight;
            end else if (goingRight) begin
                if (mX + 2 + SZ > 640) dropPending = 1'b1;
                else mX = mX + 2;
            end else begin
                if (mX < 16 + 2) dropPending = 1'b1;
                else mX = mX - 2;
            end
        end
        prevRst    = rst_pix;
        modelValid = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_pix) begin
        if (modelValid) begin
            checkOutput("colour", int'({r_o, g_o, b_o}), expColour);
            checkOutput("sync", int'({hsync_o, vsync_o, de_o}), expSync);
            checkOutput("sprX", int'(spr_x), mX);
            checkOutput("sprY", int'(spr_y), mY);
        end
    end

    task automatic applyStimulus(input int xv, input int yv, input bit h, input bit v, input bit d);
        sx      = CORDW'(xv);
        sy      = CORDW'(yv);
        hsync_i = h;
        vsync_i = v;
        de_i    = d;
        @(negedge clk_pix);
    endtask

    task automatic frameTick();
        applyStimulus(0, 480, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic probe(input string name, input int xv, input int yv, input bit d, input int colour);
        applyStimulus(xv, yv, 1'b0, 1'b0, d);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput(name, int'({r_o, g_o, b_o}), colour);
    endtask

    int animExp [5];
    int n;

    initial begin
`ifdef INVADER_ANIM_EN
        animExp = '{12'h0F0, 12'h0F0, 12'h002, 12'h002, 12'h0F0};
`else
        animExp = '{12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0};
`endif
        repeat (5) @(negedge clk_pix);
        checkOutput("rstColour", int'({r_o, g_o, b_o}), 0);
        checkOutput("rstSync", int'({hsync_o, vsync_o, de_o}), 0);
        checkOutput("rstX", int'(spr_x), 16);
        checkOutput("rstY", int'(spr_y), 32);
        rst_pix = 1'b0;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("postRst1", int'({r_o, g_o, b_o, hsync_o, vsync_o, de_o}), 0);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("postRst2", int'({r_o, g_o, b_o, hsync_o, vsync_o, de_o}), 0);

        probe("pix16_32", 16, 32, 1'b1, 12'h002);
        probe("pix28_32", 28, 32, 1'b1, 12'h0F0);
        probe("pix48_32", 48, 32, 1'b1, 12'h002);
        probe("pix15_32", 15, 32, 1'b1, 12'h002);
        probe("pix16_63", 16, 63, 1'b1, 12'h0F0);
        probe("pix47_63", 47, 63, 1'b1, 12'h0F0);
        probe("pix16_64", 16, 64, 1'b1, 12'h002);
        probe("blank28_32", 28, 32, 1'b0, 12'h000);

        applyStimulus(100, 100, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("syncDelayA", int'({hsync_o, vsync_o, de_o}), 3'b101);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("syncDelayB", int'({hsync_o, vsync_o, de_o}), 3'b010);

        for (int yy = 28; yy <= 66; yy++) begin
            for (int xx = 10; xx <= 52; xx++) begin
                applyStimulus(xx, yy, (xx % 5) == 0, (yy % 3) == 0, ((xx + yy) % 4) != 0);
            end
        end

        for (int f = 0; f < 5; f++) begin
            probe($sformatf("animFrame%0d", f), mX + 4, mY + 24, 1'b1, animExp[f]);
            frameTick();
        end

        rst_pix = 1'b1;
        applyStimulus(0, 480, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        rst_pix = 1'b0;
        checkOutput("rst2X", int'(spr_x), 16);

        repeat (296) frameTick();
        checkOutput("x296", int'(spr_x), 608);
        checkOutput("y296", int'(spr_y), 32);
        frameTick();
        checkOutput("x297", int'(spr_x), 608);
        checkOutput("y297", int'(spr_y), 32);
        frameTick();
        checkOutput("x298", int'(spr_x), 608);
        checkOutput("y298", int'(spr_y), 40);
        frameTick();
        checkOutput("x299", int'(spr_x), 606);
        probe("pixAfterDrop", 618, 40, 1'b1, 12'h0F0);

        n = 0;
        while (mY != 440 && n < 20000) begin frameTick(); n++; end
        checkOutput("y440", int'(spr_y), 440);
        n = 0;
        while (mY == 440 && n < 1000) begin frameTick(); n++; end
        checkOutput("y448", int'(spr_y), 448);
        n = 0;
        while (mY == 448 && n < 1000) begin frameTick(); n++; end
        checkOutput("yWrap", int'(spr_y), 32);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
